// File: rtl/crc_ccitt_serial.sv
// Bit-serial CRC-16/CCITT (poly 0x1021), MSB-first, non-reflected, no final XOR.
// Seed is a parameter: 16'h0000 gives XMODEM, 16'hFFFF gives CCITT-FALSE.
module crc_ccitt_serial #(
    parameter logic [15:0] init_value = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        init,
    input  logic        m,
    output logic [15:0] crc_out
);

    localparam int unsigned crc_w = 16;
    localparam logic [crc_w-1:0] poly = 16'h1021;

    logic               fb_c;
    logic [crc_w-1:0]   shifted_c;

    // One LFSR step: feedback is the outgoing MSB mixed with the message bit.
    always_comb begin
        fb_c      = crc_out[crc_w-1] ^ m;
        shifted_c = {crc_out[crc_w-2:0], 1'b0} ^ (fb_c ? poly : crc_w'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_out <= init_value;
        end else if (init) begin
            crc_out <= init_value;
        end else if (enable) begin
            crc_out <= shifted_c;
        end
    end

endmodule

// File: tb/tb_crc_ccitt_serial.sv
// Directed bench for crc_ccitt_serial: one XMODEM-seeded and one CCITT-FALSE-seeded
// instance driven in lockstep and compared against known CRC values.
module tb_crc_ccitt_serial;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        init;
    logic        m;
    logic [15:0] crc_x;
    logic [15:0] crc_f;

    int checks;
    int errors;

    crc_ccitt_serial #(.init_value(16'h0000)) dut_x (
        .clk(clk), .reset(reset), .enable(enable), .init(init), .m(m), .crc_out(crc_x)
    );

    crc_ccitt_serial #(.init_value(16'hFFFF)) dut_f (
        .clk(clk), .reset(reset), .enable(enable), .init(init), .m(m), .crc_out(crc_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one cycle, then settle just after the rising edge.
    task automatic cyc(input logic r, input logic en, input logic in, input logic mb);
        reset  = r;
        enable = en;
        init   = in;
        m      = mb;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [15:0] exp_x, input logic [15:0] exp_f);
        check({tag, "_x"}, crc_x, exp_x);
        check({tag, "_f"}, crc_f, exp_f);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end
            cyc(1'b0, 1'b1, 1'b0, b[i]);
        end
    endtask

    initial begin
        logic [7:0] digits [9];
        logic [7:0] a_byte;
        checks = 0;
        errors = 0;
        a_byte = 8'h41;
        for (int i = 0; i < 9; i++) digits[i] = 8'(8'h31 + i);

        // Reset held with random m: seed visible and held every cycle.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            check2("reset_hold", 16'h0000, 16'hFFFF);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check2("post_reset_idle", 16'h0000, 16'hFFFF);

        // Single-bit latency from the seed.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check2("one_bit_m1", 16'h1021, 16'hFFFE);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check2("init_pulse", 16'h0000, 16'hFFFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check2("one_bit_m0", 16'h0000, 16'hEFDF);

        // "A" contiguous, then stable on idle.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(a_byte, 1'b0);
        check2("a_contig", 16'h58E5, 16'hB915);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check2("a_idle", 16'h58E5, 16'hB915);

        // "123456789" contiguous.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(digits[i], 1'b0);
        check2("check_string", 16'h31C3, 16'h29B1);

        // "A" with random idle gaps.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(a_byte, 1'b1);
        check2("a_gaps", 16'h58E5, 16'hB915);

        // init after a completed frame, then "A" again.
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check2("reinit", 16'h0000, 16'hFFFF);
        send_byte(a_byte, 1'b0);
        check2("a_after_init", 16'h58E5, 16'hB915);

        // init together with enable drops the bit.
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check2("init_and_enable", 16'h0000, 16'hFFFF);
        send_byte(a_byte, 1'b0);
        check2("a_after_init_en", 16'h58E5, 16'hB915);

        // Reset mid-message discards partial CRC.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 4; i--) cyc(1'b0, 1'b1, 1'b0, a_byte[i]);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check2("reset_mid_msg", 16'h0000, 16'hFFFF);
        send_byte(a_byte, 1'b0);
        check2("a_after_reset", 16'h58E5, 16'hB915);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
